// File: rtl/iob_iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb subordinate between N_MGR IOb managers.
// One transaction in flight at a time; the grant is held until it completes.
module iob_iob_rr_arbiter #(
  parameter int N_MGR  = 2,
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic [N_MGR-1:0]           m_valid_i,
  input  logic [N_MGR*ADDR_W-1:0]    m_addr_i,
  input  logic [N_MGR*DATA_W-1:0]    m_wdata_i,
  input  logic [N_MGR*DATA_W/8-1:0]  m_wstrb_i,
  output logic [N_MGR-1:0]           m_ready_o,
  output logic [N_MGR-1:0]           m_rvalid_o,
  output logic [N_MGR*DATA_W-1:0]    m_rdata_o,
  input  logic [N_MGR-1:0]           m_rready_i,
  output logic                       s_valid_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  output logic [DATA_W/8-1:0]        s_wstrb_o,
  input  logic                       s_ready_i,
  input  logic                       s_rvalid_i,
  input  logic [DATA_W-1:0]          s_rdata_i,
  output logic                       s_rready_o,
  output logic [N_MGR-1:0]           grant_o,
  output logic                       busy_o
);

  localparam int IDX_W  = (N_MGR > 1) ? $clog2(N_MGR) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_MGR-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q,  last_d;

  logic              hi_found, lo_found, win_found;
  logic [IDX_W-1:0]  hi_idx, lo_idx, win_idx;
  logic [N_MGR-1:0]  win_oh;

  logic              g_valid, g_rready;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;

  // Rotating priority: first requester above last, otherwise the lowest requester.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N_MGR - 1; k >= 0; k--) begin
      if (m_valid_i[k]) begin
        if (k > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(k);
        end
        lo_found = 1'b1;
        lo_idx   = IDX_W'(k);
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    win_oh    = '0;
    for (int k = 0; k < N_MGR; k++) begin
      win_oh[k] = (IDX_W'(k) == win_idx);
    end
  end

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_wstrb = '0;
    for (int k = 0; k < N_MGR; k++) begin
      if (grant_q[k]) begin
        g_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
        g_wdata = m_wdata_i[k*DATA_W +: DATA_W];
        g_wstrb = m_wstrb_i[k*STRB_W +: STRB_W];
      end
    end
    g_valid  = |(m_valid_i & grant_q);
    g_rready = |(m_rready_i & grant_q);
  end

  // Handshakes: a request transfers when valid & ready are both high in a cycle;
  // a response transfers when rvalid & rready are both high in a cycle.
  always_comb begin
    s_valid_o  = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    s_rready_o = 1'b0;
    if (state_q == ST_REQ) begin
      s_valid_o = g_valid;
      s_addr_o  = g_addr;
      s_wdata_o = g_wdata;
      s_wstrb_o = g_wstrb;
      m_ready_o = grant_q & {N_MGR{s_ready_i}};
    end
    if (state_q == ST_RESP) begin
      m_rvalid_o = grant_q & {N_MGR{s_rvalid_i}};
      s_rready_o = g_rready;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_REQ;
          grant_d = win_oh;
          last_d  = win_idx;
        end
      end
      ST_REQ: begin
        if (!g_valid) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (s_ready_i) begin
          if (|g_wstrb) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (s_rvalid_i && g_rready) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_MGR - 1);
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign m_rdata_o = {N_MGR{s_rdata_i}};
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_iob_rr_arbiter.sv
// Scoreboard bench for iob_iob_rr_arbiter with four managers: forwarded requests
// and routed responses are compared against expected packets queued at drive time.
module tb_iob_iob_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            cke_i, rst_i;
  logic [N-1:0]    m_valid_i, m_ready_o, m_rvalid_o, m_rready_i, grant_o;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_wdata_i, m_rdata_o;
  logic [N*SW-1:0] m_wstrb_i;
  logic            s_valid_o, s_ready_i, s_rvalid_i, s_rready_o, busy_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o, s_rdata_i;
  logic [SW-1:0]   s_wstrb_o;

  iob_iob_rr_arbiter #(.N_MGR(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_wstrb_i(m_wstrb_i), .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_rready_i(m_rready_i),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_rready_o(s_rready_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] exp_rsp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int model_last = N - 1;

  logic [AW-1:0] mgr_addr[N];
  logic [DW-1:0] mgr_data[N];
  logic [SW-1:0] mgr_strb[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pkt(input int k);
    logic [N-1:0] oh;
    oh = 4'b0001 << k;
    return 64'({oh, mgr_addr[k], mgr_data[k], mgr_strb[k]});
  endfunction

  function automatic int next_mgr(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= N; i++) begin
      if (mask[(last + i) % N]) return (last + i) % N;
    end
    return last;
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    logic [DW-1:0] rd;
    if (!rst_i) begin
      if (s_valid_o && s_ready_i) begin
        check("req_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("req_fwd", 64'({grant_o, s_addr_o, s_wdata_o, s_wstrb_o}), e);
        end
      end
      if ((m_rvalid_o & m_rready_i) != '0) begin
        rd = '0;
        for (int k = 0; k < N; k++) if (m_rvalid_o[k]) rd = m_rdata_o[k*DW +: DW];
        check("rsp_pending", 64'(exp_rsp_q.size() != 0), 64'd1);
        if (exp_rsp_q.size() != 0) begin
          e = exp_rsp_q.pop_front();
          check("rsp_route", 64'({m_rvalid_o, s_rready_o, rd}), e);
        end
      end
      check("ready_onehot0", 64'($onehot0(m_ready_o)), 64'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_mgr(input int k, input bit is_write);
    mgr_addr[k] = AW'($urandom_range(0, (1 << AW) - 1));
    mgr_data[k] = $urandom;
    mgr_strb[k] = is_write ? SW'($urandom_range(1, 15)) : '0;
    m_addr_i[k*AW +: AW]  = mgr_addr[k];
    m_wdata_i[k*DW +: DW] = mgr_data[k];
    m_wstrb_i[k*SW +: SW] = mgr_strb[k];
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    mgr_addr[k] = a;
    m_addr_i[k*AW +: AW] = a;
  endtask

  task automatic wait_hs();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if ((m_ready_o & m_valid_i) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("hs_seen", 64'(ok), 64'd1);
  endtask

  // Managers in mask request writes back to back; each reloads after its handshake.
  task automatic serve_writes(input logic [N-1:0] mask, input int n);
    int w;
    int last_hs = 0;
    step();
    s_ready_i = 1'b1;
    for (int k = 0; k < N; k++) if (mask[k]) load_mgr(k, 1'b1);
    m_valid_i = mask;
    for (int t = 0; t < n; t++) begin
      w = next_mgr(mask, model_last);
      exp_q.push_back(pkt(w));
      wait_hs();
      if (t > 0) check("wr_gap", 64'(cyc - last_hs), 64'd2);
      last_hs    = cyc;
      model_last = w;
      step();
      load_mgr(w, 1'b1);
    end
    m_valid_i = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cke_i = 1'b1; rst_i = 1'b1;
    m_valid_i = '0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
    m_rready_i = '1; s_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    for (int k = 0; k < N; k++) begin
      mgr_addr[k] = '0; mgr_data[k] = '0; mgr_strb[k] = '0;
    end

    // reset state
    step(); step();
    s_rdata_i = 32'h1234_5678;
    sample();
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_s_valid", 64'(s_valid_o), 64'd0);
    check("rst_m_ready", 64'(m_ready_o), 64'd0);
    check("rst_rvalid", 64'({m_rvalid_o, s_rready_o}), 64'd0);
    check("rst_rdata0", 64'(m_rdata_o[DW-1:0]), 64'h1234_5678);
    check("rst_rdata3", 64'(m_rdata_o[3*DW +: DW]), 64'h1234_5678);

    // single write right out of reset; manager 0 has first priority
    step();
    rst_i = 1'b0;
    load_mgr(0, 1'b1);
    set_addr(0, 21'h10);
    mgr_strb[0] = 4'hF; m_wstrb_i[SW-1:0] = 4'hF;
    s_ready_i = 1'b1;
    m_valid_i = 4'b0001;
    exp_q.push_back(pkt(0));
    sample();
    check("w1_idle_s_valid", 64'(s_valid_o), 64'd0);
    sample();
    check("w1_s_valid", 64'(s_valid_o), 64'd1);
    check("w1_s_addr", 64'(s_addr_o), 64'h10);
    check("w1_m_ready", 64'(m_ready_o), 64'd1);
    step();
    m_valid_i = '0;
    sample();
    check("w1_grant_cleared", 64'(grant_o), 64'd0);
    check("w1_busy", 64'(busy_o), 64'd0);
    model_last = 0;

    // simultaneous writes from managers 0 and 1 alternate
    serve_writes(4'b0011, 6);

    // read by manager 1 with delayed ready and rvalid; manager 0 waits
    step();
    load_mgr(0, 1'b1);
    load_mgr(1, 1'b0);
    set_addr(1, 21'h20);
    s_ready_i = 1'b0;
    m_valid_i = 4'b0011;
    exp_q.push_back(pkt(1));
    step();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rd_req_wait", 64'({s_valid_o, grant_o, m_ready_o}), 64'({1'b1, 4'b0010, 4'b0000}));
      check("rd_req_addr", 64'(s_addr_o), 64'h20);
      step();
    end
    s_ready_i = 1'b1;
    sample();
    check("rd_req_ready", 64'(m_ready_o), 64'b0010);
    step();
    s_ready_i = 1'b0;
    m_valid_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("rd_resp_wait", 64'({busy_o, s_valid_o, m_ready_o, m_rvalid_o, grant_o}),
            64'({1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010}));
      step();
    end
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    exp_rsp_q.push_back(64'({4'b0010, 1'b1, 32'hDEAD_BEEF}));
    sample();
    check("rd_blocked_hs", 64'(m_ready_o), 64'd0);
    step();
    s_rvalid_i = 1'b0;
    s_ready_i  = 1'b1;
    exp_q.push_back(pkt(0));
    sample();
    check("rd_after_idle", 64'({busy_o, s_valid_o, m_ready_o}), 64'd0);
    step();
    sample();
    check("rd_then_mgr0", 64'(grant_o), 64'b0001);
    step();
    m_valid_i = '0;
    model_last = 0;

    // response back-pressure from manager 1
    step();
    load_mgr(1, 1'b0);
    set_addr(1, 21'h20);
    s_ready_i  = 1'b1;
    m_rready_i = 4'b1101;
    m_valid_i  = 4'b0010;
    exp_q.push_back(pkt(1));
    step();
    sample();
    step();
    m_valid_i  = '0;
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_hold", 64'({busy_o, s_valid_o, s_rready_o, m_rvalid_o, grant_o}),
            64'({1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010}));
      step();
    end
    m_rready_i = '1;
    exp_rsp_q.push_back(64'({4'b0010, 1'b1, 32'hCAFE_F00D}));
    sample();
    check("bp_rready", 64'(s_rready_o), 64'd1);
    step();
    s_rvalid_i = 1'b0;
    sample();
    check("bp_idle", 64'(busy_o), 64'd0);
    model_last = 1;

    // reset while manager 2 waits for read data
    step();
    load_mgr(2, 1'b0);
    s_ready_i = 1'b1;
    m_valid_i = 4'b0100;
    exp_q.push_back(pkt(2));
    step();
    sample();
    step();
    m_valid_i = '0;
    s_ready_i = 1'b0;
    sample();
    check("mr_in_resp", 64'({busy_o, grant_o}), 64'({1'b1, 4'b0100}));
    step();
    rst_i      = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0BAD_F00D;
    step();
    sample();
    check("mr_after_rst", 64'({grant_o, busy_o, m_rvalid_o, s_rready_o}), 64'd0);
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("mr_stray_rvalid", 64'({busy_o, m_rvalid_o, s_rready_o}), 64'd0);
      step();
    end
    s_rvalid_i = 1'b0;
    model_last = N - 1;

    // manager 2 withdraws in REQ; next search starts at manager 3
    load_mgr(2, 1'b1);
    s_ready_i = 1'b0;
    m_valid_i = 4'b0100;
    step();
    sample();
    check("wd_grant", 64'({grant_o, s_valid_o}), 64'({4'b0100, 1'b1}));
    step();
    m_valid_i = '0;
    sample();
    check("wd_nothing_fwd", 64'({busy_o, s_valid_o, m_ready_o}), 64'({1'b1, 1'b0, 4'b0000}));
    step();
    sample();
    check("wd_back_idle", 64'({busy_o, grant_o}), 64'd0);
    model_last = 2;
    serve_writes(4'b1011, 5);

    // clock enable low holds the arbiter in IDLE
    step();
    load_mgr(0, 1'b1);
    s_ready_i = 1'b1;
    cke_i     = 1'b0;
    m_valid_i = 4'b0001;
    exp_q.push_back(pkt(0));
    for (int i = 0; i < 2; i++) begin
      step();
      sample();
      check("cke_hold", 64'({busy_o, grant_o, s_valid_o}), 64'd0);
    end
    step();
    cke_i = 1'b1;
    step();
    sample();
    check("cke_resume", 64'(grant_o), 64'b0001);
    step();
    m_valid_i = '0;
    model_last = 0;

    // random request masks
    for (int r = 0; r < 6; r++) begin
      serve_writes(N'($urandom_range(1, 15)), $urandom_range(2, 6));
    end

    repeat (3) step();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
